data_memory_arbiter: RTL

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_pick.sv | 19 +
 rtl/data_memory_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_pkg
// Brief  : FSM state encoding and default widths for data_memory_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_ADDR_W_DEFAULT = 48;
    localparam int c_DATA_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_pick
// Brief  : Combinational 2-way picker; prio_i names the requester that wins a tie.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_arb_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio_i,
    output logic valid_o,
    output logic win_o
);

    assign valid_o = req0_i | req1_i;
    assign win_o   = (req0_i & req1_i) ? prio_i : req1_i;

endmodule : dmem_arb_pick
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module : data_memory_arbiter
// Brief  : Two-requester arbiter in front of a single-port data memory.
//          Fixed priority by default; round-robin with DMEM_ARB_RR_EN defined.
// Rev    : 1.0  initial release
// ============================================================================
module data_memory_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t              state_q, state_d;
    logic                win_q, win_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                mem_write_q, mem_write_d, mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                prio;
    logic                pick_valid;
    logic                pick_win;
    logic                sel_we;

`ifdef DMEM_ARB_RR_EN
    // Pointer names the requester favoured on the next tie.
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_IDLE && pick_valid) begin
            ptr_d = ~pick_win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign prio = ptr_q;
`else
    assign prio = 1'b0;
`endif

    dmem_arb_pick u_pick (
        .req0_i  (req0),
        .req1_i  (req1),
        .prio_i  (prio),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    assign sel_we = pick_win ? we1 : we0;

    always_comb begin
        state_d          = state_q;
        win_d            = win_q;
        gnt0_d           = 1'b0;
        gnt1_d           = 1'b0;
        rvalid0_d        = 1'b0;
        rvalid1_d        = 1'b0;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        rdata_d          = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d          = ST_ACCESS;
                    win_d            = pick_win;
                    gnt0_d           = ~pick_win;
                    gnt1_d           = pick_win;
                    mem_write_d      = sel_we;
                    mem_read_d       = ~sel_we;
                    mem_address_d    = pick_win ? addr1 : addr0;
                    mem_write_data_d = pick_win ? wdata1 : wdata0;
                end
            end
            ST_ACCESS: begin
                // The strobe registered on entry tells us which way this access went.
                state_d = mem_read_q ? ST_RESP : ST_IDLE;
            end
            ST_RESP: begin
                state_d   = ST_IDLE;
                rdata_d   = mem_read_data;
                rvalid0_d = ~win_q;
                rvalid1_d = win_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            win_q            <= 1'b0;
            gnt0_q           <= 1'b0;
            gnt1_q           <= 1'b0;
            rvalid0_q        <= 1'b0;
            rvalid1_q        <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            rdata_q          <= '0;
        end else begin
            state_q          <= state_d;
            win_q            <= win_d;
            gnt0_q           <= gnt0_d;
            gnt1_q           <= gnt1_d;
            rvalid0_q        <= rvalid0_d;
            rvalid1_q        <= rvalid1_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            rdata_q          <= rdata_d;
        end
    end

    assign gnt0           = gnt0_q;
    assign gnt1           = gnt1_q;
    assign rvalid0        = rvalid0_q;
    assign rvalid1        = rvalid1_q;
    assign rdata          = rdata_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule : data_memory_arbiter
`default_nettype wire
